keypad_matrix_scanner: RTL and testbench

Front end of the keypad entry path. Drives the row lines of a 4-row × 3-column keypad matrix and samples the column lines. Debounces the result over full scan frames and delivers exactly one one-hot key code per physical press, with a single-cycle `key_valid` pulse. Its `key_code` output feeds the `keypad_in` input of the keypad capture stage using the 12-bit one-hot encoding the display path already decodes: bits 0–8 = keys 1–9, bit 9 = 0, bit 10 = `*`, bit 11 = `#`.

---
 rtl/keypad_matrix_scanner.sv | 208 ++++++++++++++++++++
 tb/tb_keypad_matrix_scanner.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/keypad_matrix_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | keypad_matrix_scanner: 4x3 keypad row scan, frame debounce, one-hot code. |
// | Option macro: KEYPAD_AUTOREPEAT_EN (repeat key_valid while held). Rev 1.0 |
// +--------------------------------------------------------------------------+
module keypad_matrix_scanner #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  col_in,
  output logic [3:0]  row_out,
  output logic [11:0] key_code,
  output logic        key_valid,
  output logic        key_held
);

  localparam int              DIV_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]      DEB_N    = 4'(DEBOUNCE_SCANS);

  localparam logic [1:0] ST_RELEASED = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_PRESSED  = 2'd2;
  localparam logic [1:0] ST_WAIT_REL = 2'd3;

  if (SCAN_DIV < 2 || DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15 || REPEAT_SCANS < 1) begin : g_bad_param
    $error("keypad_matrix_scanner: parameter out of range");
  end

  logic [2:0]       col_s1_q, col_s2_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       row_q, row_d;
  logic [11:0]      acc_q, acc_d;
  logic [11:0]      frame_q, frame_d;
  logic             frame_done_q, frame_done_d;
  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [11:0]      cand_q, cand_d;
  logic [11:0]      key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic [11:0]      hit;
  logic             sample;
  logic             frame_single;
  logic             do_accept;

  // Row 3 carries '*', '0', '#' on columns 0..2, mapped to bits 10, 9, 11.
  always_comb begin
    hit = '0;
    case (row_q)
      2'd0:    hit[2:0]  = ~col_s2_q;
      2'd1:    hit[5:3]  = ~col_s2_q;
      2'd2:    hit[8:6]  = ~col_s2_q;
      default: hit[11:9] = {~col_s2_q[2], ~col_s2_q[0], ~col_s2_q[1]};
    endcase
  end

  always_comb begin
    sample       = (div_q == DIV_LAST);
    div_d        = sample ? '0 : DIV_W'(div_q + 1'b1);
    row_d        = sample ? 2'(row_q + 2'd1) : row_q;
    acc_d        = acc_q;
    frame_d      = frame_q;
    frame_done_d = 1'b0;
    if (sample) begin
      if (row_q == 2'd3) begin
        frame_d      = acc_q | hit;
        frame_done_d = 1'b1;
        acc_d        = '0;
      end else begin
        acc_d = acc_q | hit;
      end
    end
  end

  assign frame_single = (frame_q != 12'd0) && ((frame_q & (frame_q - 12'd1)) == 12'd0);

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam logic [15:0] REP_N = 16'(REPEAT_SCANS);
  logic [15:0] rep_q, rep_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cand_d      = cand_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    do_accept   = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_d       = rep_q;
`endif
    if (frame_done_q) begin
      case (state_q)
        ST_RELEASED: begin
          if (frame_single) begin
            cand_d = frame_q;
            cnt_d  = 4'd1;
            if (DEB_N <= 4'd1) do_accept = 1'b1;
            else               state_d   = ST_DEBOUNCE;
          end
        end
        ST_DEBOUNCE: begin
          if (frame_q == cand_q) begin
            cnt_d = 4'(cnt_q + 4'd1);
            if (4'(cnt_q + 4'd1) >= DEB_N) do_accept = 1'b1;
          end else begin
            state_d = ST_RELEASED;
            cnt_d   = 4'd0;
          end
        end
        ST_PRESSED: begin
          if (frame_q == 12'd0) begin
            cnt_d   = 4'd1;
            state_d = ST_WAIT_REL;
            if (DEB_N <= 4'd1) begin
              state_d = ST_RELEASED;
              cnt_d   = 4'd0;
            end
          end
`ifdef KEYPAD_AUTOREPEAT_EN
          if (frame_q == key_code_q) begin
            if (16'(rep_q + 16'd1) >= REP_N) begin
              key_valid_d = 1'b1;
              rep_d       = '0;
            end else begin
              rep_d = 16'(rep_q + 16'd1);
            end
          end else begin
            rep_d = '0;
          end
`endif
        end
        default: begin
          if (frame_q == 12'd0) begin
            if (4'(cnt_q + 4'd1) >= DEB_N) begin
              state_d = ST_RELEASED;
              cnt_d   = 4'd0;
            end else begin
              cnt_d = 4'(cnt_q + 4'd1);
            end
          end else begin
            // Chatter during release: back to held without a new pulse.
            state_d = ST_PRESSED;
            cnt_d   = 4'd0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_d   = '0;
`endif
          end
        end
      endcase
      if (do_accept) begin
        key_code_d  = cand_d;
        key_valid_d = 1'b1;
        state_d     = ST_PRESSED;
        cnt_d       = 4'd0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_d       = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_s1_q     <= 3'b111;
      col_s2_q     <= 3'b111;
      div_q        <= '0;
      row_q        <= 2'd0;
      acc_q        <= '0;
      frame_q      <= '0;
      frame_done_q <= 1'b0;
      state_q      <= ST_RELEASED;
      cnt_q        <= 4'd0;
      cand_q       <= '0;
      key_code_q   <= '0;
      key_valid_q  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q        <= '0;
`endif
    end else begin
      col_s1_q     <= col_in;
      col_s2_q     <= col_s1_q;
      div_q        <= div_d;
      row_q        <= row_d;
      acc_q        <= acc_d;
      frame_q      <= frame_d;
      frame_done_q <= frame_done_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cand_q       <= cand_d;
      key_code_q   <= key_code_d;
      key_valid_q  <= key_valid_d;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q        <= rep_d;
`endif
    end
  end

  assign row_out   = ~(4'b0001 << row_q);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = (state_q == ST_PRESSED) || (state_q == ST_WAIT_REL);

endmodule
`default_nettype wire

// File: tb/tb_keypad_matrix_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_keypad_matrix_scanner: directed self-checking bench, 4-cycle rows.     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_keypad_matrix_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  col_in;
  logic [3:0]  row_out;
  logic [11:0] key_code;
  logic        key_valid;
  logic        key_held;
  logic [11:0] keys = '0;

  int n_checks = 0;
  int n_errors = 0;
  int pulses   = 0;
  int base;

  keypad_matrix_scanner #(
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (3),
    .REPEAT_SCANS   (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .col_in    (col_in),
    .row_out   (row_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key pulls its column low while its row is driven.
  always_comb begin
    col_in = 3'b111;
    case (row_out)
      4'b1110: col_in = ~keys[2:0];
      4'b1101: col_in = ~keys[5:3];
      4'b1011: col_in = ~keys[8:6];
      4'b0111: col_in = ~{keys[11], keys[9], keys[10]};
      default: col_in = 3'b111;
    endcase
  end

  always @(negedge clk) if (!rst && key_valid) pulses++;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves the bench at cycle 0 of a frame (row 0 just driven).
  task automatic align();
    int guard = 0;
    while (row_out != 4'b0111 && guard < 100) begin cyc(1); guard++; end
    while (row_out != 4'b1110 && guard < 100) begin cyc(1); guard++; end
    if (guard >= 100) check_eq("align_timeout", guard, 0);
  endtask

  initial begin
    // Reset and scan sequence
    rst = 1'b1;
    cyc(3);
    check_eq("rst_row_out", row_out, 4'b1110);
    check_eq("rst_key_code", key_code, 12'h000);
    check_eq("rst_key_valid", key_valid, 0);
    check_eq("rst_key_held", key_held, 0);
    rst = 1'b0;
    cyc(4); check_eq("scan_row1", row_out, 4'b1101);
    cyc(4); check_eq("scan_row2", row_out, 4'b1011);
    cyc(4); check_eq("scan_row3", row_out, 4'b0111);
    cyc(4); check_eq("scan_row0", row_out, 4'b1110);

    // Clean press of key 5, 10 frames, then release
    align();
    base = pulses;
    keys = 12'h010;
    cyc(48); check_eq("press5_none_before", pulses - base, 0);
    cyc(1);  check_eq("press5_valid", key_valid, 1);
             check_eq("press5_code", key_code, 12'h010);
    cyc(1);  check_eq("press5_valid_1cyc", key_valid, 0);
    cyc(110); check_eq("press5_one_pulse", pulses - base, 1);
              check_eq("press5_held", key_held, 1);
    keys = 12'h000;
    cyc(34); check_eq("rel5_still_held", key_held, 1);
    cyc(16); check_eq("rel5_released", key_held, 0);
             check_eq("rel5_code_kept", key_code, 12'h010);

    // Bounce on key 9
    align();
    base = pulses;
    keys = 12'h100; cyc(16);
    keys = 12'h000; cyc(16);
    keys = 12'h100; cyc(48);
    check_eq("bounce9_none_before", pulses - base, 0);
    cyc(2);
    check_eq("bounce9_one_pulse", pulses - base, 1);
    check_eq("bounce9_code", key_code, 12'h100);
    keys = 12'h000; cyc(62);
    check_eq("bounce9_released", key_held, 0);

    // Multi-key: 1+2 together, then only 1
    align();
    base = pulses;
    keys = 12'h003; cyc(96);
    check_eq("multi_no_pulse", pulses - base, 0);
    check_eq("multi_not_held", key_held, 0);
    keys = 12'h001; cyc(50);
    check_eq("multi_key1_pulse", pulses - base, 1);
    check_eq("multi_key1_code", key_code, 12'h001);
    keys = 12'h000; cyc(62);

    // Release chatter on '#'
    align();
    base = pulses;
    keys = 12'h800; cyc(64);
    check_eq("hash_code", key_code, 12'h800);
    keys = 12'h000; cyc(32);
    check_eq("hash_chatter_held", key_held, 1);
    keys = 12'h800; cyc(64);
    check_eq("hash_single_pulse", pulses - base, 1);
    check_eq("hash_still_held", key_held, 1);
    keys = 12'h000; cyc(64);
    check_eq("hash_released", key_held, 0);

    // Hold '0': one pulse, or accept plus repeats every 5 frames
    align();
    base = pulses;
    keys = 12'h200; cyc(16 * 14);
`ifdef KEYPAD_AUTOREPEAT_EN
    check_eq("zero_repeat_pulses", pulses - base, 3);
`else
    check_eq("zero_single_pulse", pulses - base, 1);
`endif
    check_eq("zero_code", key_code, 12'h200);
    keys = 12'h000; cyc(64);

    // Reset during debounce of key 3
    align();
    base = pulses;
    keys = 12'h004; cyc(32);
    rst = 1'b1; keys = 12'h000;
    cyc(2);
    check_eq("rst_mid_row_out", row_out, 4'b1110);
    check_eq("rst_mid_code", key_code, 12'h000);
    check_eq("rst_mid_held", key_held, 0);
    rst = 1'b0;
    cyc(64);
    check_eq("rst_mid_no_pulse", pulses - base, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
